// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: compares the last PAT_LEN accepted bits
// against a runtime-loadable pattern, with overlapping or clearing match modes.
module seq_detector_param #(
  parameter int                 PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0] RESET_PAT = 4'b1111,
  parameter int                 CNT_W     = 8
) (
  input  logic                           Clock,
  input  logic                           Resetn,
  input  logic                           load,
  input  logic [PAT_LEN-1:0]             pat_in,
  input  logic                           overlap,
  input  logic                           w_valid,
  input  logic                           w,
  output logic                           z,
  output logic [CNT_W-1:0]               match_count,
  output logic [$clog2(PAT_LEN+1)-1:0]   CurState
);

  localparam int                FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
    $error("seq_detector_param: PAT_LEN must be in 2..16");
  end

  logic [PAT_LEN-1:0] pat_q,  pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q,  cnt_d;
  logic               z_q,    z_d;

  logic [PAT_LEN-1:0] hist_n;
  logic [FILL_W-1:0]  fill_n;
  logic               hit;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    z_d    = 1'b0;

    hist_n = {hist_q[PAT_LEN-2:0], w};
    fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    hit    = (fill_n == FILL_FULL) && (hist_n == pat_q);

    if (load) begin
      // A load restarts detection against the new pattern; w is dropped.
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (w_valid) begin
      if (hit) begin
        z_d = 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (overlap) begin
          hist_d = hist_n;
          fill_d = FILL_FULL;
        end else begin
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = hist_n;
        fill_d = fill_n;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      pat_q  <= RESET_PAT;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      z_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      z_q    <= z_d;
    end
  end

  assign z           = z_q;
  assign match_count = cnt_q;
  assign CurState    = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic, checked
// against a queue-based model of the accepted bit stream.
module tb_seq_detector_param;

  localparam int PAT_LEN = 4;
  localparam int FILL_W  = $clog2(PAT_LEN + 1);

  logic               Clock = 1'b0;
  logic               Resetn, load, overlap, w_valid, w;
  logic [PAT_LEN-1:0] pat_in;
  logic               z, z2;
  logic [7:0]         mc;
  logic [1:0]         mc2;
  logic [FILL_W-1:0]  cs, cs2;

  always #5 Clock = ~Clock;

  seq_detector_param #(.PAT_LEN(PAT_LEN), .RESET_PAT(4'b1111), .CNT_W(8)) u_dut (
    .Clock(Clock), .Resetn(Resetn), .load(load), .pat_in(pat_in),
    .overlap(overlap), .w_valid(w_valid), .w(w),
    .z(z), .match_count(mc), .CurState(cs)
  );

  // Narrow-counter copy to exercise saturation.
  seq_detector_param #(.PAT_LEN(PAT_LEN), .RESET_PAT(4'b1111), .CNT_W(2)) u_dut_sat (
    .Clock(Clock), .Resetn(Resetn), .load(load), .pat_in(pat_in),
    .overlap(overlap), .w_valid(w_valid), .w(w),
    .z(z2), .match_count(mc2), .CurState(cs2)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: accepted bits since the last clear, oldest first.
  bit               m_bits[$];
  logic [PAT_LEN-1:0] m_pat;
  int               m_cnt;
  bit               m_z;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic bit tail_matches();
    if (m_bits.size() < PAT_LEN) return 1'b0;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (m_bits[m_bits.size() - PAT_LEN + i] != m_pat[PAT_LEN-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input bit rn, input bit ld, input logic [PAT_LEN-1:0] pi,
                      input bit ov, input bit wv, input bit wb);
    Resetn  = rn;
    load    = ld;
    pat_in  = pi;
    overlap = ov;
    w_valid = wv;
    w       = wb;
    @(posedge Clock);
    m_z = 1'b0;
    if (!rn) begin
      m_pat = 4'b1111;
      m_bits.delete();
      m_cnt = 0;
    end else if (ld) begin
      m_pat = pi;
      m_bits.delete();
      m_cnt = 0;
    end else if (wv) begin
      m_bits.push_back(wb);
      while (m_bits.size() > PAT_LEN) void'(m_bits.pop_front());
      if (tail_matches()) begin
        m_z = 1'b1;
        m_cnt++;
        if (!ov) m_bits.delete();
      end
    end
    #1;
    check("z", 32'(z), 32'(m_z));
    check("z_sat", 32'(z2), 32'(m_z));
    check("match_count", 32'(mc), (m_cnt > 255) ? 32'd255 : 32'(m_cnt));
    check("match_count_sat", 32'(mc2), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    check("CurState", 32'(cs), 32'(m_bits.size()));
    check("CurState_sat", 32'(cs2), 32'(m_bits.size()));
  endtask

  task automatic stream(input bit ov, input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1, 0, '0, ov, 1, bits[i]);
  endtask

  initial begin
    Resetn = 1'b0; load = 1'b0; pat_in = '0; overlap = 1'b0; w_valid = 1'b0; w = 1'b0;
    step(0, 0, '0, 0, 0, 0);
    step(0, 0, '0, 1, 1, 1);

    // Default pattern, overlapping: matches on bits 4, 5, 6.
    stream(1, 32'b111111, 6);
    check("plan1_count", 32'(mc), 32'd3);

    // Non-overlapping: matches on bits 4 and 8 only.
    step(1, 1, 4'b1111, 0, 0, 0);
    stream(0, 32'b11111111, 8);
    check("plan2_count", 32'(mc), 32'd2);

    // Pattern 1101 in both modes.
    step(1, 1, 4'b1101, 1, 0, 0);
    stream(1, 32'b1101101, 7);
    check("plan3_ov_count", 32'(mc), 32'd2);
    step(1, 1, 4'b1101, 0, 0, 0);
    stream(0, 32'b1101101, 7);
    check("plan3_nov_count", 32'(mc), 32'd1);

    // Gap in w_valid holds history.
    step(1, 1, 4'b1111, 1, 0, 0);
    stream(1, 32'b11, 2);
    for (int i = 0; i < 3; i++) step(1, 0, '0, 1, 0, 0);
    check("plan4_gap_fill", 32'(cs), 32'd2);
    stream(1, 32'b11, 2);
    check("plan4_count", 32'(mc), 32'd1);

    // Saturation on the narrow counter: eight 1s give five matches.
    step(1, 1, 4'b1111, 1, 0, 0);
    stream(1, 32'b11111111, 8);
    check("plan5_sat", 32'(mc2), 32'd3);
    check("plan5_wide", 32'(mc), 32'd5);

    // Reset and load mid-sequence.
    stream(1, 32'b111, 3);
    step(0, 0, '0, 1, 1, 1);
    stream(1, 32'b1, 1);
    check("plan6_reset_fill", 32'(cs), 32'd1);
    stream(1, 32'b111, 3);
    step(1, 1, 4'b1010, 1, 1, 1);
    stream(1, 32'b1, 1);
    check("plan6_load_fill", 32'(cs), 32'd1);
    stream(1, 32'b010, 3);
    check("plan6_new_pat", 32'(mc), 32'd1);

    // All-zero pattern needs a full history before matching.
    step(1, 1, 4'b0000, 1, 0, 0);
    stream(1, 32'b00000, 5);
    check("zero_pat_count", 32'(mc), 32'd2);

    // Random traffic with occasional reset/load and mode changes.
    for (int i = 0; i < 3000; i++) begin
      bit rn, ld, ov, wv, wb;
      logic [PAT_LEN-1:0] pi;
      rn = ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 79) == 0);
      pi = PAT_LEN'($urandom);
      ov = ($urandom_range(0, 9) < 6);
      wv = ($urandom_range(0, 3) != 0);
      wb = 1'($urandom);
      step(rn, ld, pi, ov, wv, wb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
